mvm_mac: RTL
============

MVM_MAC -- requirements
Module: mvm_mac

Interface
REQ-001 SHALL provide parameter MATRIX_ROWS, default 6, number of matrix rows and result elements.
REQ-002 SHALL provide parameter SHARED_DIM, default 3, number of matrix columns and vector elements; SHALL be at least 1.
REQ-003 SHALL provide parameter DATA_W, default 8, width of each signed two's-complement matrix and vector element.
REQ-004 SHALL provide parameter ACC_W, default 20, width of each signed accumulator and result element.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand set valid.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 matrix  input  MATRIX_ROWS*SHARED_DIM*DATA_W  element (r,c) at bits [(r*SHARED_DIM+c)*DATA_W +: DATA_W].
REQ-010 vector  input  SHARED_DIM*DATA_W  element c at bits [c*DATA_W +: DATA_W].
REQ-011 relu_en  input  1  clamp negative results to zero for this operation.
REQ-012 result  output  MATRIX_ROWS*ACC_W  element r at bits [r*ACC_W +: ACC_W].
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 busy  output  1  high in COMPUTE or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; no new operands SHALL be accepted in COMPUTE or DONE.
REQ-018 Accept occurs on a clk edge with in_valid=1 and in_ready=1: latch matrix, vector, relu_en; clear all accumulators; clear column index; IDLE->COMPUTE.
REQ-019 Operands SHALL be used only from the latched copy; input changes after acceptance SHALL NOT affect the result.
REQ-020 In COMPUTE, each edge SHALL add matrix(r,c)*vector(c) to accumulator r for all rows in parallel, c = column index, then increment c.
REQ-021 Products SHALL be full 2*DATA_W signed, sign-extended to ACC_W; accumulation SHALL wrap modulo 2^ACC_W (no saturation); ACC_W >= 2*DATA_W+clog2(SHARED_DIM) guarantees exactness.
REQ-022 On the edge performing column SHARED_DIM-1, SHALL go COMPUTE->DONE; latency from accept edge to out_valid=1 SHALL be exactly SHARED_DIM cycles.
REQ-023 In DONE, out_valid SHALL be 1 and result SHALL hold stable until out_ready=1.
REQ-024 result element r SHALL equal accumulator r, or 0 when latched relu_en=1 and accumulator r is negative; result SHALL be 0 outside DONE.
REQ-025 On an edge with out_valid=1 and out_ready=1, SHALL go DONE->IDLE; in_ready rises the following cycle (minimum two idle-to-idle gap: one IDLE cycle between operations).
REQ-026 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-027 Column index width SHALL be clog2(SHARED_DIM) with minimum 1 bit; SHARED_DIM=1 SHALL give latency 1.

Reset
REQ-028 On reset=1 at an edge, from any state including mid-COMPUTE, SHALL enter IDLE, clear accumulators, column index, latched operands and relu flag.
REQ-029 During and after reset: in_ready=1, out_valid=0, busy=0, result=0; any in-flight operation SHALL be discarded with no out_valid.

Verification
REQ-030 Reset: assert reset 2 cycles -> in_ready=1, out_valid=0, busy=0, result=0.
REQ-031 Basic: defaults, row r = [r+1, 1, -1], vector [2,3,4] -> out_valid exactly 3 cycles after accept, results [1,3,5,7,9,11].
REQ-032 Extremes: all matrix and vector elements -128 -> every result 49152 (no wrap in ACC_W=20).
REQ-033 ReLU: row 0 = [-1,-1,-1], vector [1,2,2], relu_en=1 -> result[0]=0; same with relu_en=0 -> result[0]=-5.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, out_valid=1, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle, next operand set accepted and correct.
REQ-035 Reset mid-operation: reset one cycle after accept -> no out_valid; subsequent operation yields correct result untouched by discarded data.

Source files
------------

// File: rtl/mvm_mac_if.sv
// Operand/result handshake bundle for mvm_mac.
// master: operand source and result sink; slave: mvm_mac.
interface mvm_mac_if #(
  parameter int MATRIX_ROWS = 6,
  parameter int SHARED_DIM  = 3,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 20
);
  logic                                    in_valid;
  logic                                    in_ready;
  logic [MATRIX_ROWS*SHARED_DIM*DATA_W-1:0] matrix;
  logic [SHARED_DIM*DATA_W-1:0]            vector;
  logic                                    relu_en;
  logic [MATRIX_ROWS*ACC_W-1:0]            result;
  logic                                    out_valid;
  logic                                    out_ready;
  logic                                    busy;

  modport master (
    output in_valid, matrix, vector, relu_en, out_ready,
    input  in_ready, result, out_valid, busy
  );

  modport slave (
    input  in_valid, matrix, vector, relu_en, out_ready,
    output in_ready, result, out_valid, busy
  );
endinterface

// File: rtl/mvm_mac.sv
// Matrix-vector multiply: one column per cycle, all rows in parallel.
// Ports: clk, reset (sync, active-high), bus (mvm_mac_if.slave).
module mvm_mac #(
  parameter int MATRIX_ROWS = 6,
  parameter int SHARED_DIM  = 3,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 20
) (
  input  logic      clk,
  input  logic      reset,
  mvm_mac_if.slave  bus
);
  localparam int CW = (SHARED_DIM > 1) ? $clog2(SHARED_DIM) : 1;
  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic relu_q, relu_d;
  logic [ACC_W-1:0] acc_q [MATRIX_ROWS];
  logic [ACC_W-1:0] acc_d [MATRIX_ROWS];
  logic signed [DATA_W-1:0] mat_q [MATRIX_ROWS][SHARED_DIM];
  logic signed [DATA_W-1:0] mat_d [MATRIX_ROWS][SHARED_DIM];
  logic signed [DATA_W-1:0] vec_q [SHARED_DIM];
  logic signed [DATA_W-1:0] vec_d [SHARED_DIM];
  logic signed [PW-1:0] prod [MATRIX_ROWS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      relu_q  <= 1'b0;
      for (int r = 0; r < MATRIX_ROWS; r++) begin
        acc_q[r] <= '0;
        for (int c = 0; c < SHARED_DIM; c++)
          mat_q[r][c] <= '0;
      end
      for (int c = 0; c < SHARED_DIM; c++)
        vec_q[c] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      relu_q  <= relu_d;
      acc_q   <= acc_d;
      mat_q   <= mat_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    for (int r = 0; r < MATRIX_ROWS; r++)
      prod[r] = mat_q[r][col_q] * vec_q[col_q];
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    relu_d  = relu_q;
    acc_d   = acc_q;
    mat_d   = mat_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          for (int r = 0; r < MATRIX_ROWS; r++) begin
            acc_d[r] = '0;
            for (int c = 0; c < SHARED_DIM; c++)
              mat_d[r][c] =
                bus.matrix[(r*SHARED_DIM+c)*DATA_W +: DATA_W];
          end
          for (int c = 0; c < SHARED_DIM; c++)
            vec_d[c] = bus.vector[c*DATA_W +: DATA_W];
          relu_d  = bus.relu_en;
          col_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // Sign-extend the full product, then wrap into ACC_W.
        for (int r = 0; r < MATRIX_ROWS; r++)
          acc_d[r] = acc_q[r]
            + {{(ACC_W-PW){prod[r][PW-1]}}, prod[r]};
        if (col_q == CW'(SHARED_DIM - 1)) begin
          state_d = DONE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.result    = '0;
    if (state_q == DONE) begin
      for (int r = 0; r < MATRIX_ROWS; r++) begin
        if (!(relu_q && acc_q[r][ACC_W-1]))
          bus.result[r*ACC_W +: ACC_W] = acc_q[r];
      end
    end
  end
endmodule
